// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory, PC-select logic and decode.
// Decode handshake: an instruction transfers on any rising clk edge where inst_valid && inst_ready;
// inst_valid never waits on inst_ready, and inst/inst_pc are held stable while inst_valid=1 and inst_ready=0.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic [6:0]      opCode;
  logic [2:0]      fun3;
  logic [6:0]      fun7;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_target,
    output inst_valid,
    input  inst_ready,
    output inst, inst_pc, opCode, fun3, fun7
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    output redirect_valid, redirect_target,
    input  inst_valid,
    output inst_ready,
    input  inst, inst_pc, opCode, fun3, fun7
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem read at a time and hands the
// fetched word to decode, discarding wrong-path data after a redirect.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic            req_q;
  logic [XLEN-1:0] addr_q;
  logic            valid_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            kill_q;

  logic [XLEN-1:0] tgt_d;
  logic [XLEN-1:0] pc_inc_d;

  assign tgt_d    = {bus.redirect_target[XLEN-1:2], 2'b00};
  assign pc_inc_d = pc_q + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      addr_q    <= RESET_PC;
      valid_q   <= 1'b0;
      inst_q    <= NOP_INST;
      inst_pc_q <= RESET_PC;
      kill_q    <= 1'b0;
    end else begin
      req_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
          if (bus.redirect_valid) begin
            pc_q   <= tgt_d;
            addr_q <= tgt_d;
          end else begin
            addr_q <= {pc_q[XLEN-1:2], 2'b00};
          end
        end
        S_REQ: begin
          state_q <= S_WAIT;
          // The read already issued belongs to the old path; mark its response for discard.
          if (bus.redirect_valid) begin
            pc_q   <= tgt_d;
            kill_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.redirect_valid) begin
            pc_q <= tgt_d;
            if (bus.imem_rvalid) begin
              kill_q  <= 1'b0;
              state_q <= S_REQ;
              req_q   <= 1'b1;
              addr_q  <= tgt_d;
            end else begin
              kill_q <= 1'b1;
            end
          end else if (bus.imem_rvalid) begin
            if (kill_q) begin
              kill_q  <= 1'b0;
              state_q <= S_REQ;
              req_q   <= 1'b1;
              addr_q  <= {pc_q[XLEN-1:2], 2'b00};
            end else begin
              inst_q    <= bus.imem_rdata;
              inst_pc_q <= pc_q;
              valid_q   <= 1'b1;
              state_q   <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // Redirect takes priority over a handshake in the same cycle.
          if (bus.redirect_valid) begin
            pc_q    <= tgt_d;
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            state_q <= S_REQ;
            req_q   <= 1'b1;
            addr_q  <= tgt_d;
          end else if (valid_q && bus.inst_ready) begin
            pc_q    <= pc_inc_d;
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            state_q <= S_REQ;
            req_q   <= 1'b1;
            addr_q  <= {pc_inc_d[XLEN-1:2], 2'b00};
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.opCode     = inst_q[6:0];
  assign bus.fun3       = inst_q[14:12];
  assign bus.fun7       = inst_q[31:25];
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, back-pressure, redirects in each state,
// PC wrap-around and reset during an outstanding read.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000),
    .NOP_INST(NOP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.master),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int passed;

  // ---------------- memory driver ----------------
  bit          mem_auto;
  bit          mem_pend;
  logic [31:0] mem_data;

  // One step: advance to the next falling edge and update the memory responder,
  // which answers a request exactly one cycle after it was issued.
  task automatic cyc();
    @(negedge clk);
    if (mem_auto) begin
      bus.imem_rvalid = mem_pend;
      bus.imem_rdata  = mem_data;
      mem_pend        = bus.imem_req;
    end
  endtask

  task automatic mem_on();
    mem_auto = 1'b1;
    mem_pend = bus.imem_req;
  endtask

  task automatic mem_off();
    mem_auto        = 1'b0;
    mem_pend        = 1'b0;
    bus.imem_rvalid = 1'b0;
  endtask

  task automatic wait_req(output logic [31:0] a, output bit ok);
    ok = 1'b0;
    a  = '0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus.imem_req) begin
        a  = bus.imem_addr;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_valid(output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n++;
      if (bus.inst_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    checks++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", bus.imem_req); else passed++;
    checks++; if (bus.imem_addr !== 32'h0) $display("FAIL rst_addr got %h exp 00000000", bus.imem_addr); else passed++;
    checks++; if (bus.inst_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", bus.inst_valid); else passed++;
    checks++; if (bus.inst !== NOP) $display("FAIL rst_inst got %h exp %h", bus.inst, NOP); else passed++;
    checks++; if (bus.inst_pc !== 32'h0) $display("FAIL rst_inst_pc got %h exp 00000000", bus.inst_pc); else passed++;
    checks++; if ({bus.fun7, bus.fun3, bus.opCode} !== 17'b0000000_000_0010011) $display("FAIL rst_fields got %b exp 00000000000010011", {bus.fun7, bus.fun3, bus.opCode}); else passed++;
    checks++; if (dbg_state !== 2'd0) $display("FAIL rst_state got %0d exp 0", dbg_state); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    bit          ok;
    int          n;
    mem_data       = 32'h00A0_0093;
    bus.inst_ready = 1'b1;
    mem_on();
    for (int i = 0; i < 3; i++) begin
      wait_req(a, ok);
      checks++; if (!ok || a !== 32'(i * 4)) $display("FAIL seq_addr%0d got %h ok=%0d exp %h", i, a, ok, 32'(i * 4)); else passed++;
      wait_valid(n, ok);
      checks++; if (!ok || n != 2) $display("FAIL seq_latency%0d got %0d ok=%0d exp 2", i, n, ok); else passed++;
      checks++; if (bus.inst_pc !== 32'(i * 4)) $display("FAIL seq_pc%0d got %h exp %h", i, bus.inst_pc, 32'(i * 4)); else passed++;
      checks++; if (bus.inst !== 32'h00A0_0093) $display("FAIL seq_inst%0d got %h exp 00a00093", i, bus.inst); else passed++;
      checks++; if (bus.opCode !== 7'b0010011 || bus.fun3 !== 3'b000) $display("FAIL seq_fields%0d got %b/%b exp 0010011/000", i, bus.opCode, bus.fun3); else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    bit          ok;
    int          n;
    wait_req(a, ok);
    checks++; if (!ok || a !== 32'hC) $display("FAIL bp_addr got %h ok=%0d exp 0000000c", a, ok); else passed++;
    bus.inst_ready = 1'b0;
    mem_data       = 32'h4020_80B3;
    wait_valid(n, ok);
    checks++; if (!ok) $display("FAIL bp_valid_timeout got 0 exp 1"); else passed++;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'hC || bus.inst !== 32'h4020_80B3 || bus.imem_req !== 1'b0)
        $display("FAIL bp_hold%0d got v=%b pc=%h inst=%h req=%b exp v=1 pc=0000000c inst=402080b3 req=0", i, bus.inst_valid, bus.inst_pc, bus.inst, bus.imem_req);
      else passed++;
    end
    checks++; if (bus.fun7 !== 7'b0100000 || bus.opCode !== 7'b0110011) $display("FAIL bp_fields got %b/%b exp 0100000/0110011", bus.fun7, bus.opCode); else passed++;
    bus.inst_ready = 1'b1;
    mem_off();
    wait_req(a, ok);
    checks++; if (!ok || a !== 32'h10) $display("FAIL bp_next_addr got %h ok=%0d exp 00000010", a, ok); else passed++;
  endtask

  task automatic test_redirect_wait();
    cyc();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0102;
    cyc();
    bus.redirect_valid = 1'b0;
    checks++; if (dbg_state !== 2'd2 || bus.imem_req !== 1'b0) $display("FAIL rw_wait got st=%0d req=%b exp st=2 req=0", dbg_state, bus.imem_req); else passed++;
    cyc();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    cyc();
    bus.imem_rvalid = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) $display("FAIL rw_refetch got req=%b addr=%h exp req=1 addr=00000100", bus.imem_req, bus.imem_addr); else passed++;
    checks++; if (bus.inst_valid !== 1'b0 || bus.inst !== NOP) $display("FAIL rw_discard got v=%b inst=%h exp v=0 inst=%h", bus.inst_valid, bus.inst, NOP); else passed++;
  endtask

  task automatic test_redirect_hold();
    bit ok;
    int n;
    mem_data       = 32'h0000_0033;
    bus.inst_ready = 1'b0;
    mem_on();
    wait_valid(n, ok);
    checks++; if (!ok || bus.inst_pc !== 32'h100) $display("FAIL rh_pc got %h ok=%0d exp 00000100", bus.inst_pc, ok); else passed++;
    bus.inst_ready      = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0040;
    cyc();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.inst_valid !== 1'b0 || bus.inst !== NOP) $display("FAIL rh_drop got v=%b inst=%h exp v=0 inst=%h", bus.inst_valid, bus.inst, NOP); else passed++;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) $display("FAIL rh_addr got req=%b addr=%h exp req=1 addr=00000040", bus.imem_req, bus.imem_addr); else passed++;
  endtask

  task automatic test_wrap_and_redirect_req();
    logic [31:0] a;
    bit          ok;
    int          n;
    bus.inst_ready = 1'b0;
    wait_valid(n, ok);
    checks++; if (!ok || bus.inst_pc !== 32'h40) $display("FAIL wr_pc40 got %h ok=%0d exp 00000040", bus.inst_pc, ok); else passed++;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFF;
    cyc();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wr_top got req=%b addr=%h exp req=1 addr=fffffffc", bus.imem_req, bus.imem_addr); else passed++;
    wait_valid(n, ok);
    checks++; if (!ok || bus.inst_pc !== 32'hFFFF_FFFC) $display("FAIL wr_top_pc got %h ok=%0d exp fffffffc", bus.inst_pc, ok); else passed++;
    bus.inst_ready = 1'b1;
    wait_req(a, ok);
    checks++; if (!ok || a !== 32'h0) $display("FAIL wr_wrap got %h ok=%0d exp 00000000", a, ok); else passed++;
    // redirect during the REQ cycle: the response to address 0 must be discarded
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0200;
    cyc();
    bus.redirect_valid = 1'b0;
    checks++; if (dbg_state !== 2'd2) $display("FAIL rq_state got %0d exp 2", dbg_state); else passed++;
    cyc();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200 || bus.inst_valid !== 1'b0)
      $display("FAIL rq_refetch got req=%b addr=%h v=%b exp req=1 addr=00000200 v=0", bus.imem_req, bus.imem_addr, bus.inst_valid);
    else passed++;
  endtask

  task automatic test_reset_mid_fetch();
    bit ok;
    int n;
    mem_off();
    cyc();
    checks++; if (dbg_state !== 2'd2) $display("FAIL rm_in_wait got %0d exp 2", dbg_state); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (dbg_state !== 2'd0 || bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0 || bus.inst !== NOP || bus.inst_pc !== 32'h0)
      $display("FAIL rm_reset got st=%0d req=%b addr=%h v=%b inst=%h pc=%h exp 0/0/0/0/%h/0", dbg_state, bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst, bus.inst_pc, NOP);
    else passed++;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_0BAD;
    cyc();
    rst_n = 1'b1;
    cyc();
    bus.imem_rvalid = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0)
      $display("FAIL rm_first_fetch got req=%b addr=%h v=%b exp req=1 addr=00000000 v=0", bus.imem_req, bus.imem_addr, bus.inst_valid);
    else passed++;
    mem_data = 32'h0010_0113;
    mem_on();
    wait_valid(n, ok);
    checks++; if (!ok || bus.inst_pc !== 32'h0 || bus.inst !== 32'h0010_0113)
      $display("FAIL rm_refetch_data got pc=%h inst=%h ok=%0d exp pc=00000000 inst=00100113", bus.inst_pc, bus.inst, ok);
    else passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks              = 0;
    passed              = 0;
    mem_auto            = 1'b0;
    mem_pend            = 1'b0;
    mem_data            = '0;
    rst_n               = 1'b0;
    bus.imem_rvalid     = 1'b0;
    bus.imem_rdata      = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.inst_ready      = 1'b0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap_and_redirect_req();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control unit.
- Holds the PC and issues one instruction-memory read at a time.
- Presents the fetched word to decode with a valid/ready handshake, as a full instruction plus the opCode/fun3/fun7 slices the control unit consumes.
- Accepts redirects (taken branch, jal, jalr) from the branch/PC-select logic and discards any wrong-path instruction.

Parameters:
- XLEN, 32, width of PC, addresses and instruction word.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, instruction word driven while nothing valid is held (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  read request to instruction memory, one-cycle pulse.
- imem_addr  output  XLEN  word-aligned fetch address; low 2 bits always 0.
- imem_rvalid  input  1  read data valid; at most one response per request, earliest one cycle after imem_req.
- imem_rdata  input  XLEN  instruction word, sampled when imem_rvalid=1.
- redirect_valid  input  1  single-cycle redirect strobe.
- redirect_target  input  XLEN  new PC; bits [1:0] ignored.
- inst_valid  output  1  decode-side valid.
- inst_ready  input  1  decode-side ready.
- inst  output  XLEN  held instruction (NOP_INST when inst_valid=0).
- inst_pc  output  XLEN  PC of the held instruction.
- opCode  output  7  inst[6:0].
- fun3  output  3  inst[14:12].
- fun7  output  7  inst[31:25].

Behaviour:
- All state is in flops with async clear on rst_n=0. Reset values:
  - state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - inst_valid=0, inst=NOP_INST, inst_pc=RESET_PC, kill=0.
- FSM states and transitions:
  - IDLE: entered only from reset; moves to REQ on the first clock after rst_n deasserts.
  - REQ: imem_req=1, imem_addr={pc[XLEN-1:2],2'b00}, always for exactly one cycle; next state WAIT.
  - WAIT: stays until imem_rvalid=1.
    - If kill=0: capture inst=imem_rdata and inst_pc=pc; inst_valid=1 from the next cycle; go HOLD.
    - If kill=1: drop the data, clear kill, go REQ.
  - HOLD: inst, inst_pc and inst_valid are stable while inst_ready=0. On inst_valid & inst_ready at a clock edge: pc<=pc+4, inst_valid<=0, inst<=NOP_INST, go REQ.
- Redirect (redirect_valid=1 at a clock edge), with pc<={redirect_target[XLEN-1:2],2'b00} in every state:
  - IDLE: IDLE still proceeds to REQ; the first fetch uses the redirected pc.
  - REQ: the request in flight is stale; set kill=1, go WAIT.
  - WAIT: set kill=1. If imem_rvalid arrives in the same cycle, discard that data immediately, kill stays 0, go REQ.
  - HOLD: drop the held instruction; inst_valid<=0, inst<=NOP_INST; go REQ. Redirect wins over a simultaneous inst_ready; pc becomes the target, not pc+4.
- Timing:
  - Best-case latency is REQ→WAIT→HOLD. With the memory responding one cycle after the request, inst_valid rises 2 cycles after imem_req.
  - Peak throughput is one instruction per 3 cycles.
- PC arithmetic is modulo 2^XLEN: pc=32'hFFFF_FFFC accepted → next fetch at 32'h0000_0000.
- imem_rvalid outside WAIT (including a late response after a mid-fetch reset) is ignored.
- opCode/fun3/fun7 are pure combinational slices of the inst register. They are NOP fields (0010011, 000, 0000000) whenever inst_valid=0.

Test Plan:
- Reset release, memory returns 32'h00A00093 one cycle after each request, inst_ready=1 → imem_addr sequence 0,4,8; inst_valid pulses with inst_pc 0,4,8; opCode=0010011, fun3=000.
- Hold inst_ready=0 for 5 cycles with inst_valid=1 → inst and inst_pc stable, no imem_req. Raise ready → next imem_addr = inst_pc+4.
- Redirect to 32'h0000_0102 in WAIT, old response arrives 2 cycles later → response discarded, no inst_valid; next imem_addr=32'h0000_0100.
- Redirect in HOLD coincident with inst_ready=1, target 32'h40 → inst_valid drops; next imem_addr=32'h40, not pc+4.
- pc=32'hFFFF_FFFC accepted → next imem_addr=32'h0.
- Assert rst_n=0 during WAIT, then the late imem_rvalid arrives → all outputs at reset values, late data ignored, first post-reset fetch at RESET_PC.
